// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for an HLS dataflow region: raises block once a masked AXIS stall with all
// watched instances idle has persisted THRESH consecutive cycles; also tracks first channel and event count.
module hls_deadlock_persist_monitor #(
  parameter int NUM_AXIS = 8,
  parameter int NUM_INST = 19,
  parameter int THRESH   = 16,
  parameter int STICKY   = 1,
  parameter int IDX_W    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_watch_mask,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_idle_mask,
  input  logic                clear,
  output logic                block,
  output logic                block_pending,
  output logic [IDX_W-1:0]    first_axis_idx,
  output logic [15:0]         block_count
);

  localparam int CNT_W = (THRESH < 1) ? 1 : $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DETECTED
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [NUM_AXIS-1:0] masked_block;
  logic               all_idle;
  logic               cand;
  logic [IDX_W-1:0]   low_idx;
  logic               capture;
  logic               enter_det;
  logic [15:0]        count_q;

  assign masked_block = axis_block_sigs & axis_watch_mask;
  // Unwatched instances read as idle so an all-zero mask leaves the idle term true.
  assign all_idle     = &(inst_idle_sigs | ~inst_idle_mask);
  assign cand         = (|masked_block) & all_idle;
  assign block_count  = count_q;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (masked_block[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    enter_det = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand) begin
          capture = 1'b1;
          if (THRESH == 1) begin
            state_n   = ST_DETECTED;
            cnt_n     = CNT_MAX;
            enter_det = 1'b1;
          end else begin
            state_n = ST_ARMED;
            cnt_n   = CNT_ONE;
          end
        end else begin
          cnt_n = '0;
        end
      end
      ST_ARMED: begin
        if (!cand) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = ST_DETECTED;
          cnt_n     = CNT_MAX;
          enter_det = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_DETECTED: begin
        if (STICKY == 0 && !cand) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    // clear overrides everything, including a detection on this very edge.
    if (clear) begin
      state_n   = ST_IDLE;
      cnt_n     = '0;
      capture   = 1'b0;
      enter_det = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      block          <= 1'b0;
      block_pending  <= 1'b0;
      first_axis_idx <= '0;
      count_q        <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      block         <= (state_n == ST_DETECTED);
      block_pending <= (state_n == ST_ARMED);
      if (capture) first_axis_idx <= low_idx;
      if (enter_det && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Directed bench: table of sticky-mode vectors plus hand sequences for non-sticky, THRESH=1,
// counter saturation and asynchronous reset.
module tb_hls_deadlock_persist_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  axis_block_sigs = '0;
  logic [7:0]  axis_watch_mask = '0;
  logic [18:0] inst_idle_sigs  = '0;
  logic [18:0] inst_idle_mask  = '0;
  logic        clear = 1'b0;

  logic        block_s, pend_s, block_n, pend_n, block_t, pend_t;
  logic [2:0]  idx_s, idx_n, idx_t;
  logic [15:0] count_s, count_n, count_t;

  int checks = 0;
  int fails  = 0;

  localparam logic [18:0] ALL19 = 19'h7FFFF;
  localparam logic [18:0] NO3   = 19'h7FFF7;

  always #5 clock = ~clock;

  hls_deadlock_persist_monitor #(.NUM_AXIS(8), .NUM_INST(19), .THRESH(4), .STICKY(1), .IDX_W(3)) dut_s (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_watch_mask(axis_watch_mask),
    .inst_idle_sigs(inst_idle_sigs), .inst_idle_mask(inst_idle_mask), .clear(clear),
    .block(block_s), .block_pending(pend_s), .first_axis_idx(idx_s), .block_count(count_s));

  hls_deadlock_persist_monitor #(.NUM_AXIS(8), .NUM_INST(19), .THRESH(4), .STICKY(0), .IDX_W(3)) dut_n (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_watch_mask(axis_watch_mask),
    .inst_idle_sigs(inst_idle_sigs), .inst_idle_mask(inst_idle_mask), .clear(clear),
    .block(block_n), .block_pending(pend_n), .first_axis_idx(idx_n), .block_count(count_n));

  hls_deadlock_persist_monitor #(.NUM_AXIS(8), .NUM_INST(19), .THRESH(1), .STICKY(0), .IDX_W(3)) dut_t (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_watch_mask(axis_watch_mask),
    .inst_idle_sigs(inst_idle_sigs), .inst_idle_mask(inst_idle_mask), .clear(clear),
    .block(block_t), .block_pending(pend_t), .first_axis_idx(idx_t), .block_count(count_t));

  typedef struct {
    logic [7:0]  axis;
    logic [7:0]  amask;
    logic [18:0] idle;
    logic [18:0] imask;
    logic        clr;
    logic        e_block;
    logic        e_pend;
    logic [2:0]  e_idx;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] axis, input logic [7:0] amask, input logic [18:0] idle,
                         input logic [18:0] imask, input logic clr, input logic e_block,
                         input logic e_pend, input logic [2:0] e_idx, input logic [15:0] e_count);
    vecs.push_back('{axis, amask, idle, imask, clr, e_block, e_pend, e_idx, e_count});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic [7:0] axis, input logic [7:0] amask, input logic [18:0] idle,
                                input logic [18:0] imask, input logic clr);
    @(negedge clock);
    axis_block_sigs = axis;
    axis_watch_mask = amask;
    inst_idle_sigs  = idle;
    inst_idle_mask  = imask;
    clear           = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    axis_block_sigs = '0;
    axis_watch_mask = 8'hFF;
    inst_idle_sigs  = ALL19;
    inst_idle_mask  = ALL19;
    clear           = 1'b0;
    reset           = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Sticky THRESH=4 vectors: outputs expected after each rising edge.
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 0);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 0);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 0);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 1, 0, 5, 1);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 0, 1, 0, 5, 1);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 1, 0, 0, 5, 1);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 1);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 1);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 0, 1, 5, 1);
    add_vec(8'h20, 8'hFF, ALL19, ALL19, 0, 1, 0, 5, 2);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 1, 0, 0, 5, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 0, 0, 0, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 0, 1, 0, 2);
    add_vec(8'h01, 8'hFF, ALL19, ALL19, 0, 1, 0, 0, 3);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 1, 0, 0, 0, 3);
    add_vec(8'h06, 8'hFB, ALL19, ALL19, 0, 0, 1, 1, 3);
    add_vec(8'h06, 8'hFB, NO3,   ALL19, 0, 0, 0, 1, 3);
    add_vec(8'h06, 8'hFB, NO3,   ALL19, 0, 0, 0, 1, 3);
    add_vec(8'h06, 8'h00, ALL19, ALL19, 0, 0, 0, 1, 3);
    add_vec(8'h80, 8'hFF, NO3,   NO3,   0, 0, 1, 7, 3);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 0, 0, 0, 7, 3);
    add_vec(8'h40, 8'hFF, ALL19, ALL19, 0, 0, 1, 6, 3);
    add_vec(8'h40, 8'hBF, ALL19, ALL19, 0, 0, 0, 6, 3);
    add_vec(8'h10, 8'hFF, ALL19, ALL19, 0, 0, 1, 4, 3);
    add_vec(8'h11, 8'hFF, ALL19, ALL19, 0, 0, 1, 4, 3);
    add_vec(8'h00, 8'hFF, ALL19, ALL19, 0, 0, 0, 4, 3);

    do_reset();
    check_output("reset block", 32'(block_s), 0);
    check_output("reset pending", 32'(pend_s), 0);
    check_output("reset idx", 32'(idx_s), 0);
    check_output("reset count", 32'(count_s), 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].axis, vecs[i].amask, vecs[i].idle, vecs[i].imask, vecs[i].clr);
      check_output($sformatf("vec%0d block", i), 32'(block_s), 32'(vecs[i].e_block));
      check_output($sformatf("vec%0d pending", i), 32'(pend_s), 32'(vecs[i].e_pend));
      check_output($sformatf("vec%0d idx", i), 32'(idx_s), 32'(vecs[i].e_idx));
      check_output($sformatf("vec%0d count", i), 32'(count_s), 32'(vecs[i].e_count));
    end

    // Non-sticky: block follows cand after detection, re-entry counts again.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
      check_output("ns arm pending", 32'(pend_n), 1);
      check_output("ns arm block", 32'(block_n), 0);
    end
    apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
    check_output("ns det block", 32'(block_n), 1);
    check_output("ns det count", 32'(count_n), 1);
    apply_stimulus(8'h00, 8'hFF, ALL19, ALL19, 0);
    check_output("ns drop block", 32'(block_n), 0);
    check_output("ns drop pending", 32'(pend_n), 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
      check_output("ns rearm block", 32'(block_n), 0);
    end
    apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
    check_output("ns redet block", 32'(block_n), 1);
    check_output("ns redet count", 32'(count_n), 2);
    apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
    check_output("ns hold block", 32'(block_n), 1);
    check_output("ns hold count", 32'(count_n), 2);

    // THRESH=1: single-cycle registered latency, then saturation of the event counter.
    do_reset();
    apply_stimulus(8'h08, 8'hFF, ALL19, ALL19, 0);
    check_output("t1 block", 32'(block_t), 1);
    check_output("t1 pending", 32'(pend_t), 0);
    check_output("t1 idx", 32'(idx_t), 3);
    check_output("t1 count", 32'(count_t), 1);
    apply_stimulus(8'h00, 8'hFF, ALL19, ALL19, 0);
    check_output("t1 drop block", 32'(block_t), 0);
    force dut_t.count_q = 16'hFFFE;
    #1;
    release dut_t.count_q;
    #1;
    check_output("sat preload", 32'(count_t), 32'h0000FFFE);
    apply_stimulus(8'h08, 8'hFF, ALL19, ALL19, 0);
    check_output("sat first", 32'(count_t), 32'h0000FFFF);
    apply_stimulus(8'h00, 8'hFF, ALL19, ALL19, 0);
    check_output("sat drop block", 32'(block_t), 0);
    apply_stimulus(8'h08, 8'hFF, ALL19, ALL19, 0);
    check_output("sat hold", 32'(count_t), 32'h0000FFFF);
    check_output("sat block", 32'(block_t), 1);

    // Asynchronous reset between edges while armed / detected.
    apply_stimulus(8'h00, 8'hFF, ALL19, ALL19, 1);
    apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
    apply_stimulus(8'h20, 8'hFF, ALL19, ALL19, 0);
    check_output("pre-reset pending", 32'(pend_s), 1);
    check_output("pre-reset idx", 32'(idx_s), 5);
    check_output("pre-reset t1 block", 32'(block_t), 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async pending", 32'(pend_s), 0);
    check_output("async idx", 32'(idx_s), 0);
    check_output("async block", 32'(block_s), 0);
    check_output("async t1 block", 32'(block_t), 0);
    check_output("async t1 count", 32'(count_t), 0);
    check_output("async t1 idx", 32'(idx_t), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
